// File: rtl/pr_bus_pkg.sv
// Shared types for the CPU/DMA peripheral-bus arbiter.
// Holds FSM state, master id and the latched bus request record.
package pr_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    OWN_CPU,
    OWN_DMA
  } arb_state_t;

  typedef enum logic {
    M_CPU,
    M_DMA
  } arb_master_t;

  typedef struct packed {
    logic [31:2] addr;
    logic [31:0] wd;
    logic [3:0]  be;
    logic        we;
  } bus_req_t;

endpackage

// File: rtl/pr_bus_arbiter_if.sv
// CPU, DMA and bridge signals of the peripheral-bus arbiter.
// slave: arbiter view; master: requester/bridge environment view.
interface pr_bus_arbiter_if;

  logic        cpu_req;
  logic [31:2] cpu_addr;
  logic [31:0] cpu_wd;
  logic [3:0]  cpu_be;
  logic        cpu_we;
  logic        cpu_ack;
  logic [31:0] cpu_rd;
  logic        cpu_stall;

  logic        dma_req;
  logic [31:2] dma_addr;
  logic [31:0] dma_wd;
  logic [3:0]  dma_be;
  logic        dma_we;
  logic        dma_lock;
  logic        dma_ack;
  logic [31:0] dma_rd;

  logic [31:2] PrAddr;
  logic [31:0] PrWD;
  logic [3:0]  PrBE;
  logic        IOWrite;
  logic [31:0] PrRD;
  logic        PrReady;
  logic        bus_err;

  modport slave (
    input  cpu_req, cpu_addr, cpu_wd,
    input  cpu_be, cpu_we,
    input  dma_req, dma_addr, dma_wd,
    input  dma_be, dma_we, dma_lock,
    input  PrRD, PrReady,
    output cpu_ack, cpu_rd, cpu_stall,
    output dma_ack, dma_rd,
    output PrAddr, PrWD, PrBE,
    output IOWrite, bus_err
  );

  modport master (
    output cpu_req, cpu_addr, cpu_wd,
    output cpu_be, cpu_we,
    output dma_req, dma_addr, dma_wd,
    output dma_be, dma_we, dma_lock,
    output PrRD, PrReady,
    input  cpu_ack, cpu_rd, cpu_stall,
    input  dma_ack, dma_rd,
    input  PrAddr, PrWD, PrBE,
    input  IOWrite, bus_err
  );

endinterface

// File: rtl/pr_arb_timeout.sv
// Owner wait-state counter for the bus arbiter.
// expired fires on the LIMIT-th consecutive cycle without PrReady.
module pr_arb_timeout #(
  parameter int unsigned LIMIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic tick,
  output logic expired
);

  localparam logic [7:0] LAST = 8'(LIMIT - 1);

  logic [7:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= cnt + 8'd1;
    end
  end

  assign expired = tick & (cnt == LAST);

endmodule

// File: rtl/pr_bus_arbiter.sv
// CPU/DMA arbiter in front of the peripheral bridge.
// Optional owner timeout with bus_err: define PR_ARB_TIMEOUT_EN.
module pr_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 15,
  parameter int unsigned MAX_LOCK       = 8
) (
  input logic             clk,
  input logic             rst,
  pr_bus_arbiter_if.slave bus
);
  import pr_bus_pkg::*;

  localparam logic [7:0] LOCK_LAST = 8'(MAX_LOCK - 1);

  arb_state_t  state, state_nxt;
  arb_master_t last_grant, last_nxt;
  logic [7:0]  lock_cnt, lock_nxt;
  bus_req_t    q, q_nxt;
  bus_req_t    cpu_r, dma_r;

  logic own_cpu, own_dma, owner;
  logic done, expired, stay;
  logic cpu_ack, dma_ack;
  logic tmo_clr, tmo_tick;

  assign cpu_r = {bus.cpu_addr, bus.cpu_wd,
                  bus.cpu_be, bus.cpu_we};
  assign dma_r = {bus.dma_addr, bus.dma_wd,
                  bus.dma_be, bus.dma_we};

  assign own_cpu  = (state == OWN_CPU);
  assign own_dma  = (state == OWN_DMA);
  assign owner    = own_cpu | own_dma;
  assign done     = owner & (bus.PrReady | expired);
  assign tmo_clr  = ~owner | done;
  assign tmo_tick = owner & ~bus.PrReady;

`ifdef PR_ARB_TIMEOUT_EN
  pr_arb_timeout #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_tmo (
    .clk     (clk),
    .rst     (rst),
    .clr     (tmo_clr),
    .tick    (tmo_tick),
    .expired (expired)
  );
`else
  localparam logic [7:0] TMO8 = 8'(TIMEOUT_CYCLES);
  logic unused_tmo;
  assign unused_tmo = ^{TMO8, tmo_clr, tmo_tick};
  assign expired    = 1'b0;
`endif

  // a locked burst only continues on a real completion
  assign stay = bus.PrReady & bus.dma_lock
              & bus.dma_req
              & (lock_cnt < LOCK_LAST);

  always_comb begin
    state_nxt = state;
    last_nxt  = last_grant;
    lock_nxt  = lock_cnt;
    q_nxt     = q;
    unique case (state)
      IDLE: begin
        if (bus.cpu_req &&
            (!bus.dma_req || last_grant == M_DMA)) begin
          state_nxt = OWN_CPU;
          q_nxt     = cpu_r;
        end else if (bus.dma_req) begin
          state_nxt = OWN_DMA;
          q_nxt     = dma_r;
        end
      end
      OWN_CPU: begin
        if (done) begin
          state_nxt = IDLE;
          last_nxt  = M_CPU;
        end
      end
      OWN_DMA: begin
        if (done) begin
          last_nxt = M_DMA;
          if (stay) begin
            q_nxt    = dma_r;
            lock_nxt = lock_cnt + 8'd1;
          end else begin
            state_nxt = IDLE;
            lock_nxt  = '0;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= M_DMA;
      lock_cnt   <= '0;
      q          <= '0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_nxt;
      lock_cnt   <= lock_nxt;
      q          <= q_nxt;
    end
  end

  assign cpu_ack = own_cpu & done;
  assign dma_ack = own_dma & done;

  assign bus.cpu_ack   = cpu_ack;
  assign bus.dma_ack   = dma_ack;
  assign bus.cpu_rd    = (cpu_ack & bus.PrReady)
                       ? bus.PrRD : '0;
  assign bus.dma_rd    = (dma_ack & bus.PrReady)
                       ? bus.PrRD : '0;
  assign bus.cpu_stall = bus.cpu_req & ~cpu_ack;

  assign bus.PrAddr  = q.addr;
  assign bus.PrWD    = q.wd;
  assign bus.PrBE    = q.be;
  assign bus.IOWrite = owner & q.we & ~expired;
  assign bus.bus_err = expired;

endmodule

// File: tb/tb_pr_bus_arbiter.sv
// Self-checking bench for pr_bus_arbiter: directed scenarios
// plus random traffic against a transaction-level reference model.
module tb_pr_bus_arbiter;

  localparam int TMO = 15;
  localparam int ML  = 8;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  pr_bus_arbiter_if bif ();

  pr_bus_arbiter #(
    .TIMEOUT_CYCLES(TMO),
    .MAX_LOCK      (ML)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  int    n_run  = 0;
  int    n_fail = 0;
  string ph     = "init";

  // model: who holds the bus, what it asked for, and history
  int          m_own;
  int          m_last;
  int          m_burst;
  int          m_wait;
  logic [29:0] m_addr;
  logic [31:0] m_wd;
  logic [3:0]  m_be;
  logic        m_we;

  logic        e_fin, e_tmo;
  logic        e_cack, e_dack, e_iow, e_err, e_stall;
  logic [31:0] e_crd, e_drd;

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s/%s: got %0h want %0h",
             ph, tag, obs, exp);
    end
  endtask

  task automatic grab(int who);
    m_own  = who;
    m_wait = 0;
    if (who == 1) begin
      m_addr = bif.cpu_addr; m_wd = bif.cpu_wd;
      m_be   = bif.cpu_be;   m_we = bif.cpu_we;
    end else begin
      m_addr = bif.dma_addr; m_wd = bif.dma_wd;
      m_be   = bif.dma_be;   m_we = bif.dma_we;
    end
  endtask

  task automatic model_eval();
    e_tmo = 1'b0;
`ifdef PR_ARB_TIMEOUT_EN
    e_tmo = (m_own != 0) && !bif.PrReady
         && (m_wait + 1 >= TMO);
`endif
    e_fin   = (m_own != 0) && (bif.PrReady || e_tmo);
    e_cack  = e_fin && (m_own == 1);
    e_dack  = e_fin && (m_own == 2);
    e_crd   = (e_cack && !e_tmo) ? bif.PrRD : 32'h0;
    e_drd   = (e_dack && !e_tmo) ? bif.PrRD : 32'h0;
    e_iow   = (m_own != 0) && m_we && !e_tmo;
    e_err   = e_tmo;
    e_stall = bif.cpu_req && !e_cack;
  endtask

  task automatic model_adv();
    if (rst) begin
      m_own = 0; m_last = 2; m_burst = 0; m_wait = 0;
      m_addr = '0; m_wd = '0; m_be = '0; m_we = 1'b0;
    end else if (m_own == 0) begin
      if (bif.cpu_req && (!bif.dma_req || m_last == 2))
        grab(1);
      else if (bif.dma_req)
        grab(2);
    end else if (e_fin) begin
      m_last = m_own;
      if (m_own == 2 && !e_tmo && bif.dma_lock &&
          bif.dma_req && (m_burst + 1 < ML)) begin
        m_burst++;
        grab(2);
      end else begin
        m_own   = 0;
        m_burst = 0;
      end
    end else begin
      m_wait++;
    end
  endtask

  task automatic look();
    #3;
    model_eval();
    chk("cpu_ack", 32'(bif.cpu_ack), 32'(e_cack));
    chk("dma_ack", 32'(bif.dma_ack), 32'(e_dack));
    chk("cpu_rd", bif.cpu_rd, e_crd);
    chk("dma_rd", bif.dma_rd, e_drd);
    chk("stall", 32'(bif.cpu_stall), 32'(e_stall));
    chk("iowrite", 32'(bif.IOWrite), 32'(e_iow));
    chk("bus_err", 32'(bif.bus_err), 32'(e_err));
    chk("praddr", 32'(bif.PrAddr), 32'(m_addr));
    chk("prwd", bif.PrWD, m_wd);
    chk("prbe", 32'(bif.PrBE), 32'(m_be));
  endtask

  task automatic adv();
    model_adv();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] ba;

    rst = 1'b1;
    bif.cpu_req = 0; bif.cpu_addr = '0; bif.cpu_wd = '0;
    bif.cpu_be = '0; bif.cpu_we = 0;
    bif.dma_req = 0; bif.dma_addr = '0; bif.dma_wd = '0;
    bif.dma_be = '0; bif.dma_we = 0; bif.dma_lock = 0;
    bif.PrRD = '0; bif.PrReady = 0;
    m_own = 0; m_last = 2; m_burst = 0; m_wait = 0;
    m_addr = '0; m_wd = '0; m_be = '0; m_we = 0;
    @(posedge clk);
    #1;

    ph = "reset";
    bif.PrReady = 1;
    look();
    chk("rst_acks", 32'({bif.cpu_ack, bif.dma_ack}), 32'd0);
    chk("rst_addr", 32'(bif.PrAddr), 32'd0);
    adv();
    rst = 1'b0;

    ph = "tie";
    bif.cpu_req = 1; bif.dma_req = 1;
    bif.cpu_addr = 30'h11; bif.dma_addr = 30'h22;
    bif.PrRD = 32'hA5A5_0001;
    look(); chk("c0_idle", 32'(bif.cpu_ack), 32'd0); adv();
    look(); chk("c1_cpu", 32'(bif.cpu_ack), 32'd1);
    chk("c1_addr", 32'(bif.PrAddr), 32'h11); adv();
    look(); chk("c2_idle", 32'(bif.dma_ack), 32'd0); adv();
    look(); chk("c3_dma", 32'(bif.dma_ack), 32'd1);
    chk("c3_rd", bif.dma_rd, 32'hA5A5_0001); adv();
    look(); adv();
    look(); chk("c5_cpu", 32'(bif.cpu_ack), 32'd1); adv();
    bif.cpu_req = 0; bif.dma_req = 0;
    look(); adv();

    ph = "rd_wait";
    ba = 32'h1FC0;
    bif.cpu_req = 1; bif.cpu_addr = ba[31:2];
    bif.PrRD = 32'hDEAD_BEEF;
    for (int i = 0; i < 4; i++) begin
      bif.PrReady = (i == 0);
      look();
      chk("stall_hi", 32'(bif.cpu_stall), 32'd1);
      chk("no_ack", 32'(bif.cpu_ack), 32'd0);
      adv();
    end
    bif.PrReady = 1;
    look();
    chk("ack", 32'(bif.cpu_ack), 32'd1);
    chk("rd", bif.cpu_rd, 32'hDEAD_BEEF);
    chk("addr", 32'(bif.PrAddr), 32'(ba[31:2]));
    adv();
    bif.cpu_req = 0;

    ph = "write";
    bif.cpu_req = 1; bif.cpu_we = 1; bif.cpu_be = 4'b0011;
    bif.cpu_wd = 32'h1234_5678; bif.PrReady = 0;
    look(); adv();
    bif.cpu_req = 0; bif.cpu_wd = 32'h0;
    for (int i = 0; i < 2; i++) begin
      look();
      chk("iow", 32'(bif.IOWrite), 32'd1);
      chk("be", 32'(bif.PrBE), 32'b0011);
      chk("wd", bif.PrWD, 32'h1234_5678);
      adv();
    end
    bif.PrReady = 1;
    look(); chk("late_ack", 32'(bif.cpu_ack), 32'd1); adv();
    bif.cpu_we = 0;

    ph = "lock";
    bif.cpu_req = 1; bif.dma_req = 1; bif.dma_lock = 1;
    bif.dma_addr = 30'd100;
    look(); adv();
    for (int i = 0; i < ML; i++) begin
      look();
      chk("dack", 32'(bif.dma_ack), 32'd1);
      chk("addr", 32'(bif.PrAddr), 32'(100 + i));
      bif.dma_addr = 30'(101 + i);
      adv();
    end
    look(); chk("gap", 32'(bif.dma_ack), 32'd0); adv();
    look(); chk("cpu_after", 32'(bif.cpu_ack), 32'd1); adv();
    bif.cpu_req = 0; bif.dma_req = 0; bif.dma_lock = 0;
    look(); adv();

    ph = "timeout";
    bif.cpu_req = 1; bif.cpu_we = 1; bif.PrReady = 0;
    look(); adv();
    bif.cpu_req = 0;
`ifdef PR_ARB_TIMEOUT_EN
    for (int k = 1; k < TMO; k++) begin
      look(); chk("wait", 32'(bif.cpu_ack), 32'd0); adv();
    end
    look();
    chk("tmo_ack", 32'(bif.cpu_ack), 32'd1);
    chk("tmo_err", 32'(bif.bus_err), 32'd1);
    chk("tmo_iow", 32'(bif.IOWrite), 32'd0);
    adv();
`else
    for (int k = 0; k < 100; k++) begin
      look(); chk("hang", 32'(bif.cpu_ack), 32'd0); adv();
    end
    bif.PrReady = 1;
    look(); chk("release", 32'(bif.cpu_ack), 32'd1); adv();
`endif
    bif.cpu_we = 0;

    ph = "mid_rst";
    bif.dma_req = 1; bif.dma_we = 1; bif.PrReady = 0;
    look(); adv();
    look(); chk("own_iow", 32'(bif.IOWrite), 32'd1); adv();
    rst = 1;
    look(); adv();
    rst = 0; bif.dma_req = 0; bif.PrReady = 1;
    look();
    chk("no_dack", 32'(bif.dma_ack), 32'd0);
    chk("iow0", 32'(bif.IOWrite), 32'd0);
    adv();
    bif.dma_we = 0;

    ph = "random";
    for (int i = 0; i < 800; i++) begin
      rst          = ($urandom_range(0, 99) == 0);
      bif.cpu_req  = ($urandom_range(0, 99) < 45);
      bif.dma_req  = ($urandom_range(0, 99) < 45);
      bif.dma_lock = ($urandom_range(0, 99) < 60);
      bif.PrReady  = ($urandom_range(0, 99) < 70);
      bif.cpu_addr = 30'($urandom);
      bif.dma_addr = 30'($urandom);
      bif.cpu_wd   = $urandom;
      bif.dma_wd   = $urandom;
      bif.cpu_be   = 4'($urandom);
      bif.dma_be   = 4'($urandom);
      bif.cpu_we   = 1'($urandom);
      bif.dma_we   = 1'($urandom);
      bif.PrRD     = $urandom;
      look();
      adv();
    end
    rst = 0;

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/pr_bus_arbiter.md
PR_BUS_ARBITER -- requirements
Module: pr_bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 15, meaning owner-state cycles without PrReady before abort (range 2..255).
REQ-002 SHALL have parameter MAX_LOCK, default 8, meaning maximum back-to-back locked DMA transactions per tenure (range 1..255).
REQ-003 SHALL have port clk, input, 1, meaning the single system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, meaning reset; synchronous and active-high.
REQ-005 SHALL have ports cpu_req (in, 1), cpu_addr (in, 30, [31:2]), cpu_wd (in, 32), cpu_be (in, 4), cpu_we (in, 1), meaning the CPU data-port request.
REQ-006 SHALL have ports cpu_ack (out, 1), cpu_rd (out, 32), cpu_stall (out, 1), meaning the CPU completion pulse, read data and pipeline stall.
REQ-007 SHALL have ports dma_req, dma_addr, dma_wd, dma_be, dma_we (same widths as CPU) and dma_lock (in, 1), meaning the DMA request and its bus-lock hint.
REQ-008 SHALL have ports dma_ack (out, 1) and dma_rd (out, 32), meaning the DMA completion pulse and read data.
REQ-009 SHALL have ports PrAddr (out, 30, [31:2]), PrWD (out, 32), PrBE (out, 4), IOWrite (out, 1), PrRD (in, 32), PrReady (in, 1), bus_err (out, 1), meaning the bridge side.

Function
REQ-010 SHALL implement FSM states IDLE, OWN_CPU, OWN_DMA.
- IDLE: only cpu_req -> OWN_CPU; only dma_req -> OWN_DMA; both -> the master not in last_grant; neither -> IDLE.
REQ-011 SHALL latch the winner's addr/wd/be/we into bus registers on the grant edge; PrAddr/PrWD/PrBE drive these registers.
REQ-012 SHALL assert IOWrite = latched_we in an owner state, else 0.
REQ-013 SHALL, in an owner state with PrReady=1, assert that owner's ack for exactly that cycle, with its rd = PrRD combinationally; the other ack and rd SHALL be 0.
REQ-014 SHALL give a minimum latency of one cycle: req sampled in cycle N, ack in cycle N+1 if PrReady=1 then.
REQ-015 SHALL set last_grant to the owner on every ack.
REQ-016 SHALL, at ack in OWN_CPU, return to IDLE, leaving one idle cycle between transactions.
REQ-017 SHALL, at ack in OWN_DMA, take one of two paths.
- Stay: dma_lock=1, dma_req=1 and lock_cnt<MAX_LOCK-1 -> stay in OWN_DMA, relatch DMA fields, increment lock_cnt.
- Leave: otherwise -> IDLE with lock_cnt cleared.
REQ-018 SHALL drive cpu_stall = cpu_req & ~cpu_ack.
REQ-019 SHALL complete a granted transaction even if its req drops before ack; the ack is still emitted.
REQ-020 SHALL keep bus registers stable in IDLE (hold last value) and SHALL ignore PrReady in IDLE.

Reset
REQ-021 SHALL, with rst=1, on the next edge force the following regardless of other inputs, including mid-transaction: state IDLE, bus registers 0, lock_cnt 0, timeout count 0, last_grant=DMA (CPU wins first tie).
REQ-022 SHALL hold all outputs at 0 while in reset-induced IDLE (acks, IOWrite, bus_err, rd, cpu_stall when cpu_req=0).

Configuration
REQ-023 SHALL provide macro PR_ARB_TIMEOUT_EN.
- Defined: an 8-bit counter increments each owner cycle with PrReady=0 and clears on grant. On reaching TIMEOUT_CYCLES, force owner ack, bus_err=1 for that cycle, rd=0, IOWrite=0 that cycle, go to IDLE, clear lock_cnt.
- Undefined: no counter; bus_err tied 0; owner waits indefinitely.

Structure
REQ-024 SHALL place arb_state_t (IDLE/OWN_CPU/OWN_DMA) and master-id typedef arb_master_t in shared package pr_bus_pkg.
REQ-025 SHALL isolate the timeout counter in sub-module pr_arb_timeout (clk, rst, clr, tick, expired), instantiated only under PR_ARB_TIMEOUT_EN.

Verification
REQ-026 SHALL cover the tie: cpu_req=dma_req=1 from reset, PrReady=1 -> cpu_ack in cycle 1, dma_ack in cycle 3, then CPU next tie.
REQ-027 SHALL cover a CPU read with wait states: cpu_addr=0x1FC0, PrReady low 3 cycles, PrRD=0xDEADBEEF -> cpu_stall high 4 cycles, then cpu_ack with cpu_rd=0xDEADBEEF.
REQ-028 SHALL cover the DMA lock limit: dma_lock=1 continuous with MAX_LOCK=8, cpu_req pending -> 8 consecutive dma_ack, IDLE, then cpu_ack.
REQ-029 SHALL cover a write: cpu_we=1, cpu_be=4'b0011, cpu_wd=0x12345678 -> IOWrite=1 with PrBE=0011 and PrWD=0x12345678 until PrReady.
REQ-030 SHALL cover timeout: PrReady held 0 with macro defined -> ack and bus_err=1 in 15th owner cycle; without macro -> no ack after 100 cycles.
REQ-031 SHALL cover mid-transaction reset: rst=1 in OWN_DMA -> next cycle IDLE, IOWrite=0, no dma_ack.
